// File: rtl/digest_pkg.sv
// Shared definitions for the phrase digesters on the camera/DRAM path.
package digest_pkg;

  localparam int unsigned DEFAULT_WORD_W   = 16;
  localparam int unsigned DEFAULT_PHRASE_W = 128;

  // Number of narrow words carried by one phrase.
  function automatic int unsigned nw_f(input int unsigned phrase_w, input int unsigned word_w);
    return phrase_w / word_w;
  endfunction

  // Width of the word-slice index; never narrower than one bit.
  function automatic int unsigned idx_w_f(input int unsigned nw);
    return (nw > 1) ? unsigned'($clog2(nw)) : 1;
  endfunction

  localparam int unsigned DEFAULT_IDX_W = idx_w_f(nw_f(DEFAULT_PHRASE_W, DEFAULT_WORD_W));

  typedef logic [DEFAULT_IDX_W-1:0] word_idx_t;

endpackage

// File: rtl/digest_phrase_multi.sv
// Wide-phrase to narrow-word serialiser with frame-start and last-word flags.
// Optional statistics counters enabled by defining DIGEST_PHRASE_MULTI_STATS_EN.
module digest_phrase_multi
  import digest_pkg::*;
#(
  parameter int unsigned PHRASE_W  = DEFAULT_PHRASE_W,
  parameter int unsigned WORD_W    = DEFAULT_WORD_W,
  parameter int unsigned MSW_FIRST = 0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                valid_phrase,
  output logic                ready_phrase,
  input  logic [PHRASE_W-1:0] phrase_data,
  input  logic                phrase_tuser,
  output logic                valid_word,
  input  logic                ready_word,
  output logic [WORD_W-1:0]   word,
  output logic                newframe_out,
  output logic                last_word_out
`ifdef DIGEST_PHRASE_MULTI_STATS_EN
  ,
  output logic [15:0]         underrun_count,
  output logic [31:0]         frame_words
`endif
);

  localparam int unsigned NW    = nw_f(PHRASE_W, WORD_W);
  localparam int unsigned IDX_W = idx_w_f(NW);
  localparam int unsigned SEL_W = (PHRASE_W > 1) ? unsigned'($clog2(PHRASE_W)) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_LAST = IDX_W'(NW - 1);

  logic [PHRASE_W-1:0] holding_q, holding_d;
  logic                tuser_q, tuser_d;
  idx_t                idx_q, idx_d;
  logic                loaded_q, loaded_d;

  logic                at_last_c;
  logic                accept_c;
  logic                xfer_c;
  idx_t                slice_c;
  logic [SEL_W-1:0]    base_c;

  // Handshakes and output decode, all derived from registered state.
  always_comb begin
    at_last_c     = (idx_q == IDX_LAST);
    ready_phrase  = rst_in && (!loaded_q || (ready_word && at_last_c));
    accept_c      = valid_phrase && ready_phrase;
    xfer_c        = loaded_q && ready_word;
    slice_c       = (MSW_FIRST != 0) ? (IDX_LAST - idx_q) : idx_q;
    base_c        = SEL_W'(slice_c) * SEL_W'(WORD_W);
    valid_word    = loaded_q;
    word          = holding_q[base_c +: WORD_W];
    newframe_out  = loaded_q && tuser_q && (idx_q == '0);
    last_word_out = loaded_q && at_last_c;
  end

  // Next state: step through slices, reload on accept (same cycle as last word, no bubble).
  always_comb begin
    holding_d = holding_q;
    tuser_d   = tuser_q;
    idx_d     = idx_q;
    loaded_d  = loaded_q;
    if (xfer_c) begin
      if (!at_last_c) begin
        idx_d = idx_q + IDX_W'(1);
      end else begin
        loaded_d = 1'b0;
      end
    end
    if (accept_c) begin
      holding_d = phrase_data;
      tuser_d   = phrase_tuser;
      idx_d     = '0;
      loaded_d  = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      holding_q <= '0;
      tuser_q   <= 1'b0;
      idx_q     <= '0;
      loaded_q  <= 1'b0;
    end else begin
      holding_q <= holding_d;
      tuser_q   <= tuser_d;
      idx_q     <= idx_d;
      loaded_q  <= loaded_d;
    end
  end

`ifdef DIGEST_PHRASE_MULTI_STATS_EN
  logic        seen_q, seen_d;
  logic [15:0] underrun_q, underrun_d;
  logic [31:0] fwords_q, fwords_d;

  // Underruns count only once traffic has started; frame length restarts on a frame-start word.
  always_comb begin
    seen_d     = seen_q || accept_c;
    underrun_d = underrun_q;
    fwords_d   = fwords_q;
    if (seen_q && ready_word && !loaded_q && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
    if (xfer_c) begin
      fwords_d = newframe_out ? 32'd1 : (fwords_q + 32'd1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      seen_q     <= 1'b0;
      underrun_q <= '0;
      fwords_q   <= '0;
    end else begin
      seen_q     <= seen_d;
      underrun_q <= underrun_d;
      fwords_q   <= fwords_d;
    end
  end

  assign underrun_count = underrun_q;
  assign frame_words    = fwords_q;
`endif

endmodule

// File: tb/tb_digest_phrase_multi.sv
// Directed bench for digest_phrase_multi: default, MSW-first byte and single-word builds.
module tb_digest_phrase_multi;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_n = 0;

  // Default build.
  logic         a_vp, a_rp, a_tu, a_valid, a_rw, a_nf, a_last;
  logic [127:0] a_data;
  logic [15:0]  a_word;
  // 64-bit phrase, byte words, most-significant first.
  logic         b_vp, b_rp, b_tu, b_valid, b_rw, b_nf, b_last;
  logic [63:0]  b_data;
  logic [7:0]   b_word;
  // One word per phrase.
  logic         c_vp, c_rp, c_tu, c_valid, c_rw, c_nf, c_last;
  logic [15:0]  c_data;
  logic [15:0]  c_word;
`ifdef DIGEST_PHRASE_MULTI_STATS_EN
  logic [15:0]  a_uc, b_uc, c_uc;
  logic [31:0]  a_fw, b_fw, c_fw;
`endif

  always #5 clk = ~clk;

  digest_phrase_multi u_a (
    .clk_in(clk), .rst_in(rst_n), .valid_phrase(a_vp), .ready_phrase(a_rp),
    .phrase_data(a_data), .phrase_tuser(a_tu), .valid_word(a_valid), .ready_word(a_rw),
    .word(a_word), .newframe_out(a_nf), .last_word_out(a_last)
`ifdef DIGEST_PHRASE_MULTI_STATS_EN
    , .underrun_count(a_uc), .frame_words(a_fw)
`endif
  );

  digest_phrase_multi #(.PHRASE_W(64), .WORD_W(8), .MSW_FIRST(1)) u_b (
    .clk_in(clk), .rst_in(rst_n), .valid_phrase(b_vp), .ready_phrase(b_rp),
    .phrase_data(b_data), .phrase_tuser(b_tu), .valid_word(b_valid), .ready_word(b_rw),
    .word(b_word), .newframe_out(b_nf), .last_word_out(b_last)
`ifdef DIGEST_PHRASE_MULTI_STATS_EN
    , .underrun_count(b_uc), .frame_words(b_fw)
`endif
  );

  digest_phrase_multi #(.PHRASE_W(16), .WORD_W(16)) u_c (
    .clk_in(clk), .rst_in(rst_n), .valid_phrase(c_vp), .ready_phrase(c_rp),
    .phrase_data(c_data), .phrase_tuser(c_tu), .valid_word(c_valid), .ready_word(c_rw),
    .word(c_word), .newframe_out(c_nf), .last_word_out(c_last)
`ifdef DIGEST_PHRASE_MULTI_STATS_EN
    , .underrun_count(c_uc), .frame_words(c_fw)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc_n, got, exp);
    end
  endtask

  // Drive one cycle of inputs on the selected DUT, check its outputs, advance one clock.
  task automatic cyc(input int sel, input logic vp, input logic [127:0] d, input logic tu,
                     input logic rw, input logic ev, input logic [15:0] ew, input logic enf,
                     input logic el, input logic erp);
    logic        g_valid, g_nf, g_last, g_rp;
    logic [15:0] g_word;
    case (sel)
      0: begin a_vp = vp; a_data = d; a_tu = tu; a_rw = rw; end
      1: begin b_vp = vp; b_data = d[63:0]; b_tu = tu; b_rw = rw; end
      default: begin c_vp = vp; c_data = d[15:0]; c_tu = tu; c_rw = rw; end
    endcase
    #1;
    case (sel)
      0: begin g_valid = a_valid; g_word = a_word; g_nf = a_nf; g_last = a_last; g_rp = a_rp; end
      1: begin g_valid = b_valid; g_word = 16'(b_word); g_nf = b_nf; g_last = b_last; g_rp = b_rp; end
      default: begin g_valid = c_valid; g_word = c_word; g_nf = c_nf; g_last = c_last; g_rp = c_rp; end
    endcase
    chk("valid_word", 128'(g_valid), 128'(ev));
    if (ev) chk("word", 128'(g_word), 128'(ew));
    chk("newframe_out", 128'(g_nf), 128'(enf));
    chk("last_word_out", 128'(g_last), 128'(el));
    chk("ready_phrase", 128'(g_rp), 128'(erp));
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Drain n words of an arithmetic sequence from DUT a with no new phrase offered.
  task automatic drain(input logic [15:0] w0, input logic [15:0] stp, input logic nf0, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1'b0, '0, 1'b0, 1'b1, 1'b1, w0 + 16'(i) * stp, nf0 && (i == 0), i == 7, i == 7);
    end
  endtask

  localparam logic [127:0] P1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] P2 = {8{16'hDEAD}};
  localparam logic [127:0] P3 = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
  localparam logic [127:0] P4 = 128'hB007_B006_B005_B004_B003_B002_B001_B000;
  localparam logic [127:0] P5 = 128'hC007_C006_C005_C004_C003_C002_C001_C000;
  localparam logic [127:0] P6 = 128'hD007_D006_D005_D004_D003_D002_D001_D000;

  initial begin
    rst_n = 1'b0;
    a_vp = 0; a_data = '0; a_tu = 0; a_rw = 1;
    b_vp = 0; b_data = '0; b_tu = 0; b_rw = 1;
    c_vp = 0; c_data = '0; c_tu = 0; c_rw = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_phrase", 128'(a_rp), 128'(0));
    chk("rst_valid_word", 128'(a_valid), 128'(0));
    chk("rst_word", 128'(a_word), 128'(0));
    chk("rst_flags", 128'({a_nf, a_last}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back phrases with a 2-cycle stall on the fifth word.
    cyc(0, 1, P1, 1, 1, 0, 16'h0000, 0, 0, 1);
    cyc(0, 1, P2, 0, 1, 1, 16'h8888, 1, 0, 0);
    cyc(0, 1, P2, 0, 1, 1, 16'h7777, 0, 0, 0);
    cyc(0, 1, P2, 0, 1, 1, 16'h6666, 0, 0, 0);
    cyc(0, 1, P2, 0, 1, 1, 16'h5555, 0, 0, 0);
    cyc(0, 1, P2, 0, 0, 1, 16'h4444, 0, 0, 0);
    cyc(0, 1, P2, 0, 0, 1, 16'h4444, 0, 0, 0);
    cyc(0, 1, P2, 0, 1, 1, 16'h4444, 0, 0, 0);
    cyc(0, 1, P2, 0, 1, 1, 16'h3333, 0, 0, 0);
    cyc(0, 1, P2, 0, 1, 1, 16'h2222, 0, 0, 0);
    cyc(0, 1, P2, 0, 1, 1, 16'h1111, 0, 1, 1);
    drain(16'hDEAD, 16'h0000, 0, 8);

    // Late phrase: one idle cycle, then three idle cycles.
    cyc(0, 1, P3, 1, 1, 0, 16'h0000, 0, 0, 1);
    drain(16'hA000, 16'h0001, 1, 8);
    cyc(0, 0, P1, 1, 1, 0, 16'h0000, 0, 0, 1);
    cyc(0, 0, P1, 1, 1, 0, 16'h0000, 0, 0, 1);
    cyc(0, 1, P4, 0, 1, 0, 16'h0000, 0, 0, 1);
    drain(16'hB000, 16'h0001, 0, 3);

    // Asynchronous reset between edges after three words.
    a_vp = 0; a_rw = 1;
    #1;
    chk("pre_rst_word", 128'(a_word), 128'(16'hB003));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_word", 128'(a_valid), 128'(0));
    chk("mid_rst_ready_phrase", 128'(a_rp), 128'(0));
    chk("mid_rst_word", 128'(a_word), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh phrase after reset, idle gap of five underrun cycles, then a second frame.
    cyc(0, 1, P5, 1, 1, 0, 16'h0000, 0, 0, 1);
    drain(16'hC000, 16'h0001, 1, 8);
`ifdef DIGEST_PHRASE_MULTI_STATS_EN
    chk("frame_words_first", 128'(a_fw), 128'(32'd8));
    chk("underrun_none_yet", 128'(a_uc), 128'(16'd0));
`endif
    for (int i = 0; i < 4; i++) cyc(0, 0, P1, 0, 1, 0, 16'h0000, 0, 0, 1);
    cyc(0, 1, P6, 1, 1, 0, 16'h0000, 0, 0, 1);
    drain(16'hD000, 16'h0001, 1, 8);
`ifdef DIGEST_PHRASE_MULTI_STATS_EN
    chk("underrun_count", 128'(a_uc), 128'(16'd5));
    chk("frame_words", 128'(a_fw), 128'(32'd8));
`endif

    // MSW-first byte serialisation.
    cyc(1, 1, 128'h0102_0304_0506_0708, 1, 1, 0, 16'h0000, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, '0, 0, 1, 1, 16'(i + 1), i == 0, i == 7, i == 7);
    end
    cyc(1, 0, '0, 0, 1, 0, 16'h0000, 0, 0, 1);

    // Single-word phrases behave as a pipeline register.
    cyc(2, 1, 128'hCAFE, 1, 1, 0, 16'h0000, 0, 0, 1);
    cyc(2, 1, 128'hBEEF, 0, 1, 1, 16'hCAFE, 1, 1, 1);
    cyc(2, 0, 128'h0000, 0, 0, 1, 16'hBEEF, 0, 1, 0);
    cyc(2, 0, 128'h0000, 0, 1, 1, 16'hBEEF, 0, 1, 1);
    cyc(2, 0, 128'h0000, 0, 1, 0, 16'h0000, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d got timeout exp finish", cyc_n);
    $fatal(1, "timeout");
  end

endmodule
